// File: rtl/gcd_lcm.sv
// gcd_lcm: LCM from captured operands and the GCD engine result, L = (A / Y) * B.
// Optional GCD_LCM_TIMEOUT_EN adds a WAIT_GCD watchdog that ends the job with an error.
module gcd_lcm #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [W-1:0]   GCD_Y,
  input  logic           GCD_DONE,
  input  logic           GCD_ERROR,
  output logic [2*W-1:0] L,
  output logic           DONE,
  output logic           ERROR,
  output logic           BUSY
);
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, WAIT_GCD, DIV, MUL, FIN} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   ra_q, ra_d, rb_q, rb_d, d_q, d_d, q_q, q_d;
  logic [W:0]     rem_q, rem_d, trial, rem_n;
  logic [2*W-1:0] mc_q, mc_d, p_q, p_d, l_q, l_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ef_q, ef_d, err_q, err_d, done_q, done_d, ge, last;
`ifdef GCD_LCM_TIMEOUT_EN
  logic [7:0]     tmo_q, tmo_d;
`endif
  assign trial = {rem_q[W-1:0], q_q[W-1]};
  assign ge    = trial >= {1'b0, d_q};
  assign rem_n = ge ? trial - {1'b0, d_q} : trial;
  assign last  = cnt_q == CW'(W - 1);
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    d_d     = d_q;
    q_d     = q_q;
    rem_d   = rem_q;
    mc_d    = mc_q;
    p_d     = p_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    ef_d    = ef_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef GCD_LCM_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: if (START) begin
        ra_d    = A;
        rb_d    = B;
        l_d     = '0;
        err_d   = 1'b0;
        ef_d    = 1'b0;
        state_d = WAIT_GCD;
`ifdef GCD_LCM_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT_GCD: begin
        if (GCD_DONE) begin
          if (GCD_ERROR || GCD_Y == '0) begin
            ef_d    = 1'b1;
            state_d = FIN;
          end else begin
            d_d     = GCD_Y;
            q_d     = ra_q;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
`ifdef GCD_LCM_TIMEOUT_EN
        else if (tmo_q == 8'hFF) begin
          ef_d    = 1'b1;
          state_d = FIN;
        end else tmo_d = tmo_q + 8'd1;
`endif
      end
      DIV: begin
        rem_d = rem_n;
        q_d   = {q_q[W-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // an exact division is guaranteed for a correct GCD; a remainder flags a bad input
          ef_d    = ef_q | (rem_n != '0);
          mc_d    = {{W{1'b0}}, rb_q};
          p_d     = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d     = q_q[0] ? p_q + mc_q : p_q;
        mc_d    = mc_q << 1;
        q_d     = q_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? FIN : MUL;
      end
      FIN: begin
        done_d  = 1'b1;
        l_d     = ef_q ? '0 : p_q;
        err_d   = ef_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      d_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      mc_q    <= '0;
      p_q     <= '0;
      l_q     <= '0;
      cnt_q   <= '0;
      ef_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef GCD_LCM_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      d_q     <= d_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      mc_q    <= mc_d;
      p_q     <= p_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
      ef_q    <= ef_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef GCD_LCM_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end
  assign L     = l_q;
  assign DONE  = done_q;
  assign ERROR = err_q;
  assign BUSY  = state_q != IDLE;
endmodule

// File: tb/tb_gcd_lcm.sv
// tb_gcd_lcm: directed vectors with hand-computed LCM results for gcd_lcm (default build).
module tb_gcd_lcm;
  logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, GCD_DONE = 1'b0, GCD_ERROR = 1'b0;
  logic [7:0]  A = '0, B = '0, GCD_Y = '0;
  logic [15:0] L;
  logic        DONE, ERROR, BUSY;
  int          n_tests = 0, n_fail = 0;
  gcd_lcm #(.W(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .GCD_Y(GCD_Y),
    .GCD_DONE(GCD_DONE), .GCD_ERROR(GCD_ERROR), .L(L), .DONE(DONE), .ERROR(ERROR), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    START = 1'b1; A = a; B = b;
    cyc();
    START = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp_l,
                           input logic exp_e);
    int lat = 0, drop = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (DONE) begin lat = n; break; end
      if (!BUSY) drop++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy held"}, drop, 0);
    chk({tag, " L"}, L, exp_l);
    chk({tag, " ERROR"}, ERROR, exp_e);
    chk({tag, " BUSY low at DONE"}, BUSY, 0);
    cyc();
    chk({tag, " DONE single"}, DONE, 0);
    chk({tag, " L held"}, L, exp_l);
  endtask
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] y,
                     input logic ge, input logic [15:0] exp_l, input logic exp_e);
    start_op(a, b);
    chk({tag, " BUSY after START"}, BUSY, 1);
    if (!exp_e || ge || y == 0) chk({tag, " L cleared"}, L, 0);
    cyc(); cyc();
    GCD_DONE = 1'b1; GCD_Y = y; GCD_ERROR = ge;
    cyc();
    GCD_DONE = 1'b0; GCD_ERROR = 1'b0;
    wait_done(tag, exp_e ? 1 : 17, exp_l, exp_e);
  endtask
  initial begin
    int bad;
    cyc(); cyc();
    chk("reset L", L, 0);
    chk("reset DONE", DONE, 0);
    chk("reset ERROR", ERROR, 0);
    chk("reset BUSY", BUSY, 0);
    RST = 1'b0;
    cyc();
    run("21x6", 8'd21, 8'd6, 8'd3, 1'b0, 16'd42, 1'b0);
    run("75x60", 8'd75, 8'd60, 8'd15, 1'b0, 16'd300, 1'b0);
    run("255x254", 8'd255, 8'd254, 8'd1, 1'b0, 16'd64770, 1'b0);
    run("gcd err", 8'd7, 8'd0, 8'd1, 1'b1, 16'd0, 1'b1);
    run("gcd zero", 8'd103, 8'd103, 8'd0, 1'b0, 16'd0, 1'b1);
    // a second START during DIV must not disturb the running job
    start_op(8'd21, 8'd6);
    GCD_DONE = 1'b1; GCD_Y = 8'd3;
    cyc();
    GCD_DONE = 1'b0;
    cyc(); cyc(); cyc();
    START = 1'b1; A = 8'd9; B = 8'd4;
    cyc();
    START = 1'b0;
    wait_done("ignored start", 13, 16'd42, 1'b0);
    chk("ignored start stays idle", BUSY, 0);
    // reset in the middle of MUL
    start_op(8'd75, 8'd60);
    GCD_DONE = 1'b1; GCD_Y = 8'd15;
    cyc();
    GCD_DONE = 1'b0;
    for (int i = 0; i < 11; i++) cyc();
    chk("pre-reset BUSY", BUSY, 1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("mid reset L", L, 0);
    chk("mid reset DONE", DONE, 0);
    chk("mid reset BUSY", BUSY, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (DONE || BUSY) bad++;
    end
    chk("post reset quiet", bad, 0);
    run("8x29", 8'd8, 8'd29, 8'd1, 1'b0, 16'd232, 1'b0);
    // without the watchdog, WAIT_GCD never gives up
    start_op(8'd5, 8'd5);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (!BUSY || DONE) bad++;
    end
    chk("no timeout", bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
